mem_bus_arbiter: RTL

- Multi-master byte-wide memory bus arbiter and address decoder.
- Arbitrates NUM_MASTERS requesters onto one synchronous RAM port and one IO port. Typical masters: CPU, HCI loader, debug port.
- Decodes each request as RAM or memory-mapped IO.
- Returns read data one cycle later through a registered source/owner select.
- Generalises the top-level CPU/HCI muxing: N masters, fixed or round-robin priority, IO back-pressure, global pause.

---
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - N-master byte bus arbiter with RAM/IO decode and one-cycle read return
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int IO_SEL_WIDTH   = 3,
  parameter int ARB_MODE       = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pause,
  input  logic [NUM_MASTERS-1:0]      m_req,
  input  logic [NUM_MASTERS-1:0]      m_we,
  input  logic [32*NUM_MASTERS-1:0]   m_addr,
  input  logic [8*NUM_MASTERS-1:0]    m_wdata,
  output logic [NUM_MASTERS-1:0]      m_gnt,
  output logic [NUM_MASTERS-1:0]      m_rvalid,
  output logic [7:0]                  m_rdata,
  output logic                        ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]   ram_addr,
  output logic [7:0]                  ram_wdata,
  input  logic [7:0]                  ram_rdata,
  output logic                        io_en,
  output logic [IO_SEL_WIDTH-1:0]     io_sel,
  output logic                        io_we,
  output logic [7:0]                  io_wdata,
  input  logic [7:0]                  io_rdata,
  input  logic                        io_full,
  output logic [2:0]                  owner
);

  localparam logic [3:0] NM = 4'(NUM_MASTERS);

  logic [RAM_ADDR_WIDTH-1:0] addr_arr [8];
  logic [7:0]                wdata_arr [8];
  logic [7:0]                we_ext;
  logic [7:0]                is_io;
  logic [7:0]                elig;

  logic       rd_pending_q, rd_pending_d;
  logic [2:0] rd_owner_q, rd_owner_d;
  logic       rd_is_io_q, rd_is_io_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;

  logic       found;
  logic       grant;
  logic [2:0] win;
  logic [3:0] cand;
  logic       sel_we;
  logic       sel_io;

  // Bits above the RAM window only feed the IO decode; fold the rest away.
  logic unused_addr;
  assign unused_addr = ^m_addr;

  for (genvar i = 0; i < 8; i++) begin : g_m
    if (i < NUM_MASTERS) begin : g_used
      assign addr_arr[i]  = m_addr[32*i +: RAM_ADDR_WIDTH];
      assign wdata_arr[i] = m_wdata[8*i +: 8];
      assign we_ext[i]    = m_we[i];
      assign is_io[i]     = (m_addr[32*i+RAM_ADDR_WIDTH -: 2] == 2'b11);
      assign elig[i]      = m_req[i] & ~pause & ~(is_io[i] & m_we[i] & io_full);
      assign m_gnt[i]     = grant & (win == 3'(i));
      assign m_rvalid[i]  = rd_pending_q & (rd_owner_q == 3'(i));
    end else begin : g_pad
      assign addr_arr[i]  = '0;
      assign wdata_arr[i] = '0;
      assign we_ext[i]    = 1'b0;
      assign is_io[i]     = 1'b0;
      assign elig[i]      = 1'b0;
    end
  end

  // Round-robin search begins one past the last winner; fixed mode scans from 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (ARB_MODE == 1) begin
        cand = {1'b0, rr_ptr_q} + 4'(k) + 4'd1;
        if (cand >= NM) cand = cand - NM;
      end else begin
        cand = 4'(k);
      end
      if (!found && elig[cand[2:0]]) begin
        found = 1'b1;
        win   = cand[2:0];
      end
    end
  end

  assign grant  = found & rst_n;
  assign sel_we = we_ext[win];
  assign sel_io = is_io[win];

  // When idle win is 0, so the RAM sees master 0's address as a harmless read.
  assign ram_addr  = addr_arr[win];
  assign ram_wdata = wdata_arr[win];
  assign io_wdata  = wdata_arr[win];
  assign io_sel    = addr_arr[win][IO_SEL_WIDTH-1:0];
  assign ram_we    = grant & ~sel_io & sel_we;
  assign io_en     = grant & sel_io;
  assign io_we     = grant & sel_io & sel_we;

  assign m_rdata = rd_is_io_q ? io_rdata : ram_rdata;
  assign owner   = owner_q;

  always_comb begin
    rd_pending_d = grant & ~sel_we;
    rd_owner_d   = grant ? win : rd_owner_q;
    rd_is_io_d   = grant ? sel_io : rd_is_io_q;
    owner_d      = grant ? win : owner_q;
    rr_ptr_d     = grant ? win : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= '0;
      rd_is_io_q   <= 1'b0;
      owner_q      <= '0;
      rr_ptr_q     <= 3'(NUM_MASTERS - 1);
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      rd_is_io_q   <= rd_is_io_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule
